// File: rtl/sha3_pkg.sv
// rtl/sha3_pkg.sv - shared types and constants for the SHA3 pad buffer
// Purpose: FSM state type, lane geometry and SHA3 pad byte values.
// Ports: none (package).
package sha3_pkg;
  localparam int LANE_W             = 64;
  localparam int DEFAULT_RATE_LANES = 17;
  localparam logic [7:0] PAD_DS     = 8'h06;
  localparam logic [7:0] PAD_END    = 8'h80;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    FULL,
    PAD,
    DONE
  } state_t;
endpackage

// File: rtl/sha3_pad_buffer_if.sv
// rtl/sha3_pad_buffer_if.sv - message word stream and block hand-off bundle
// Purpose: groups the word input handshake and the held-block outputs.
// Ports (signals): data_in/data_valid/data_last/data_nbytes/data_ready word stream,
//   block_out/buff_full/first/last_block/block_ack block hand-off.
//   master = message source + datapath side, slave = pad buffer side.
interface sha3_pad_buffer_if #(
  parameter int RATE_LANES = sha3_pkg::DEFAULT_RATE_LANES
);
  logic [sha3_pkg::LANE_W-1:0]            data_in;
  logic                                   data_valid;
  logic                                   data_last;
  logic [3:0]                             data_nbytes;
  logic                                   data_ready;
  logic                                   block_ack;
  logic [sha3_pkg::LANE_W*RATE_LANES-1:0] block_out;
  logic                                   buff_full;
  logic                                   first;
  logic                                   last_block;

  modport master (
    output data_in, data_valid, data_last, data_nbytes, block_ack,
    input  data_ready, block_out, buff_full, first, last_block
  );

  modport slave (
    input  data_in, data_valid, data_last, data_nbytes, block_ack,
    output data_ready, block_out, buff_full, first, last_block
  );
endinterface

// File: rtl/sha3_byte_pad.sv
// rtl/sha3_byte_pad.sv - masks a final message word and inserts the 0x06 pad byte
// Purpose: combinational; for a last word with fewer than 8 valid bytes, zero the
//   unused bytes and place PAD_DS at byte nbytes. Other words pass through.
// Ports: word in, nbytes in (>=8 means full word), is_last in, padded out.
module sha3_byte_pad
  import sha3_pkg::*;
(
  input  logic [LANE_W-1:0] word,
  input  logic [3:0]        nbytes,
  input  logic              is_last,
  output logic [LANE_W-1:0] padded
);
  logic [2:0] nb_low;

  always_comb begin
    padded = word;
    nb_low = nbytes[2:0];
    // nbytes[3] set covers 8..15, which all mean a full word
    if (is_last && !nbytes[3]) begin
      for (int k = 0; k < 8; k++) begin
        if (k == int'(nb_low)) begin
          padded[8*k +: 8] = PAD_DS;
        end else if (k > int'(nb_low)) begin
          padded[8*k +: 8] = 8'h00;
        end
      end
    end
  end
endmodule

// File: rtl/sha3_pad_buffer.sv
// rtl/sha3_pad_buffer.sv - assembles SHA3-padded rate blocks from 64-bit words
// Purpose: collects little-endian message words into RATE_LANES lanes, applies
//   0x06..0x80 padding, holds the block until block_ack, and emits the extra
//   pad-only block when the message ends on a block boundary.
// Ports: clk, rst (sync, active-high), start (new message pulse), en (absorb
//   enable), bus (slave side: word stream in, block hand-off out).
module sha3_pad_buffer
  import sha3_pkg::*;
#(
  parameter int RATE_LANES = DEFAULT_RATE_LANES,
  parameter int CNT_W      = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             en,
  sha3_pad_buffer_if.slave bus
);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(RATE_LANES - 1);

  state_t                state, state_nxt;
  logic [LANE_W-1:0]     lanes      [RATE_LANES];
  logic [LANE_W-1:0]     lanes_fill [RATE_LANES];
  logic [LANE_W-1:0]     padded;
  logic [CNT_W-1:0]      cnt, cnt_p1;
  logic                  pad_pending, first_q, last_q;
  logic                  ready, accept, word_full, at_end;

  sha3_byte_pad u_byte_pad (
    .word    (bus.data_in),
    .nbytes  (bus.data_nbytes),
    .is_last (bus.data_last),
    .padded  (padded)
  );

  assign accept    = ready && bus.data_valid;
  assign word_full = bus.data_nbytes[3];
  assign at_end    = (cnt == LAST_IDX);
  assign cnt_p1    = cnt + 1'b1;

  // Lane image after an accepted word: the word itself plus whichever pad
  // bits the final word places in other lanes.
  always_comb begin
    for (int i = 0; i < RATE_LANES; i++) begin
      lanes_fill[i] = lanes[i];
      if (CNT_W'(i) == cnt) begin
        lanes_fill[i] = padded;
      end
      if (bus.data_last) begin
        if (!word_full && i == RATE_LANES - 1) begin
          lanes_fill[i][LANE_W-1 -: 8] = lanes_fill[i][LANE_W-1 -: 8] | PAD_END;
        end
        if (word_full && !at_end) begin
          if (CNT_W'(i) == cnt_p1) begin
            lanes_fill[i][7:0] = lanes_fill[i][7:0] | PAD_DS;
          end
          if (i == RATE_LANES - 1) begin
            lanes_fill[i][LANE_W-1 -: 8] = lanes_fill[i][LANE_W-1 -: 8] | PAD_END;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (start) begin
      state_nxt = FILL;
    end else begin
      case (state)
        IDLE: state_nxt = IDLE;
        FILL: if (accept && (bus.data_last || at_end)) state_nxt = FULL;
        FULL: if (bus.block_ack) state_nxt = pad_pending ? PAD : (last_q ? DONE : FILL);
        PAD:  state_nxt = FULL;
        DONE: state_nxt = DONE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    ready          = (state == FILL) && en;
    bus.data_ready = ready;
    bus.buff_full  = (state == FULL);
    bus.last_block = (state == FULL) && last_q;
    bus.first      = first_q;
    bus.block_out  = '0;
    for (int i = 0; i < RATE_LANES; i++) begin
      bus.block_out[LANE_W*i +: LANE_W] = lanes[i];
    end
  end

  // start restarts from any state, so it shares the clear path with rst.
  always_ff @(posedge clk) begin
    if (rst || start) begin
      for (int i = 0; i < RATE_LANES; i++) lanes[i] <= '0;
      cnt         <= '0;
      pad_pending <= 1'b0;
      first_q     <= 1'b1;
      last_q      <= 1'b0;
    end else begin
      case (state)
        FILL: begin
          if (accept) begin
            for (int i = 0; i < RATE_LANES; i++) lanes[i] <= lanes_fill[i];
            cnt <= cnt_p1;
            if (bus.data_last) begin
              // A full final word in the last lane leaves no room for padding.
              pad_pending <= word_full && at_end;
              last_q      <= !(word_full && at_end);
            end
          end
        end
        FULL: begin
          if (bus.block_ack) begin
            for (int i = 0; i < RATE_LANES; i++) lanes[i] <= '0;
            cnt     <= '0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
          end
        end
        PAD: begin
          lanes[0]            <= {{(LANE_W-8){1'b0}}, PAD_DS};
          lanes[RATE_LANES-1] <= {PAD_END, {(LANE_W-8){1'b0}}};
          pad_pending         <= 1'b0;
          last_q              <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: doc/sha3_pad_buffer.md
Name: sha3_pad_buffer

Overview:
- Upstream neighbour of the SHA3 control FSM.
- Accepts the message as 64-bit little-endian words, applies SHA3 multi-rate padding (0x06 … 0x80) and assembles one rate-sized block.
- Exposes the assembled block with buff_full, first and last_block flags, for the control FSM and the permutation/absorb datapath.
- Holds the block until the datapath acknowledges it, then refills. It generates the extra pad-only block when the message ends exactly on a block boundary.

Parameters:
- RATE_LANES, 17, number of 64-bit lanes per block (17 = SHA3-256, 1088 bits).
- CNT_W, 5, lane counter width; must satisfy 2^CNT_W > RATE_LANES.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse: begin new message; clears buffer, sets first.
- en  in  1  absorb enable from control FSM (en_vsx); words accepted only when high.
- data_in  in  64  message word; byte k = data_in[8k+7:8k].
- data_valid  in  1  data_in valid.
- data_last  in  1  qualifies final word of message.
- data_nbytes  in  4  valid bytes in the final word, 0..8; ignored unless data_last. Values 9..15 are treated as 8.
- data_ready  out  1  buffer can accept a word this cycle.
- block_ack  in  1  datapath has consumed the held block.
- block_out  out  64*RATE_LANES  assembled block; lane i = bits [64i+63:64i].
- buff_full  out  1  block complete and held.
- first  out  1  held/filling block is the first block of the message.
- last_block  out  1  held block carries the final 0x80 pad bit.

Behaviour:
- Reset (rst=1 at clock edge):
  - state=IDLE, all lanes=0, cnt=0, pad_pending=0, first=1.
  - Outputs: data_ready=0, buff_full=0, last_block=0.
  - rst wins over every other input, including mid-fill and mid-hold.
- States:
  - IDLE: start → FILL (lanes cleared, cnt=0, first=1).
  - FILL: data_ready = en. An accepted word (data_valid & data_ready) is written to lane[cnt] and cnt increments.
    - Non-last word with cnt==RATE_LANES-1 → FULL, last_block=0.
    - Last word, nbytes<8: bytes ≥ nbytes zeroed; byte nbytes of lane[cnt] |= 0x06; byte 7 of lane[RATE_LANES-1] |= 0x80; → FULL, last_block=1. If both pads land on the same byte, that byte is 0x86.
    - Last word, nbytes==8, cnt<RATE_LANES-1: byte 0 of lane[cnt+1] |= 0x06, byte 7 of lane[RATE_LANES-1] |= 0x80; → FULL, last_block=1.
    - Last word, nbytes==8, cnt==RATE_LANES-1: → FULL, last_block=0, pad_pending=1.
  - FULL: buff_full=1, data_ready=0; incoming words are ignored. On block_ack: lanes cleared, cnt=0, first←0. Next state:
    - pad_pending → PAD;
    - else last_block → DONE;
    - else → FILL.
  - PAD: single cycle; lane0 = 0x06, lane[RATE_LANES-1] = 0x8000_0000_0000_0000, pad_pending←0; → FULL with last_block=1.
  - DONE: data_ready=0, buff_full=0; start → FILL (first=1).
- start received in FILL/FULL/PAD aborts the message and behaves as from IDLE.
- Latency:
  - buff_full rises on the cycle after the accepting edge of the block-completing word.
  - buff_full drops on the cycle after the block_ack edge.
  - A block_ack while buff_full=0 is ignored.
- block_out is registered and stable while buff_full=1.
- last_block is valid only while buff_full=1; it is 0 otherwise.

Decomposition:
- Package sha3_pkg holds:
  - the state typedef (IDLE, FILL, FULL, PAD, DONE);
  - RATE_LANES default;
  - PAD_DS = 8'h06, PAD_END = 8'h80;
  - lane width 64.
- One natural sub-module: sha3_byte_pad. It is combinational: given word, nbytes and is_last, it returns the masked word with 0x06 inserted. It lets the lane write path stay a simple indexed register write.

Test Plan:
- Empty message: start; word last nbytes=0 → lane0=0x0000000000000006, lane16=0x8000000000000000, all other lanes 0; buff_full=1 next cycle; first=1, last_block=1.
- "abc": data_in=0x0000000000636261, nbytes=3, last → lane0=0x0000000006636261, lane16=0x8000000000000000; after block_ack → DONE, data_ready=0.
- 17 full words, last nbytes=8:
  - First hold: last_block=0, first=1.
  - After ack: PAD, then buff_full with lane0=0x06, lane16=0x80<<56, first=0, last_block=1.
- 17th word last with nbytes=7, data=0x00AABBCCDDEEFF11 → lane16=0x86AABBCCDDEEFF11.
- Backpressure: data_valid held during FULL → data_ready=0 and lane contents unchanged; en=0 in FILL → no word accepted, cnt unchanged.
- rst asserted after 5 words of FILL → next cycle buff_full=0, data_ready=0, block_out=0, first=1; new start plus "abc" produces the same result as the "abc" scenario.
